pipe_skid_reg: RTL and testbench

- Generalised, parametrised pipeline-stage register for the core (MEM/WB and other stage boundaries).
- Carries an arbitrary-width payload with a valid/ready handshake and a 2-entry skid buffer, so back-pressure does not drop beats.
- Supports a synchronous flush.
- Supports replay: the most recently transferred beat is re-presented for one extra transfer.
- Replaces fixed-field stage registers that have only flush and hold-last behaviour.

---
 rtl/pipe_skid_reg.sv | 142 ++++++++++++++
 tb/tb_pipe_skid_reg.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage register with a 2-entry skid
// buffer (main + skid), synchronous flush, and replay of the most recently
// transferred beat from a one-entry history register.
// Optional feature: define PIPE_SKID_STALL_CNT_EN to add stall_cnt_o, a
// saturating 16-bit count of cycles where a valid beat is held by the
// downstream (cleared by flush).
module pipe_skid_reg #(
    parameter int DATA_W = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    input  logic              flush_i,
    input  logic              replay_i,
    output logic [1:0]        occupancy_o
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    // Main entry feeds the output; skid catches the beat accepted while the
    // downstream stalls; history holds the last beat handed downstream.
    logic              m_v, s_v, h_v, rp;
    logic [DATA_W-1:0] m_d, s_d, h_d;

    logic              m_v_nx, s_v_nx, h_v_nx, rp_nx;
    logic [DATA_W-1:0] m_d_nx, s_d_nx, h_d_nx;

    logic              up_fire, dn_fire;

    // While replaying, the history beat overrides main on the output.
    assign dn_valid_o  = rp | m_v;
    assign dn_data_o   = rp ? h_d : m_d;
    // Upstream is blocked when the skid is full, during replay, or on flush.
    assign up_ready_o  = !s_v && !rp && !flush_i;
    assign occupancy_o = {1'b0, m_v} + {1'b0, s_v};

    assign up_fire = up_valid_i & up_ready_o;
    assign dn_fire = dn_valid_o & dn_ready_i;

    // Next-state selection: flush, then replay-active, then normal streaming.
    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so branches
        // that leave a register alone cannot infer a latch.
        m_v_nx = m_v;
        m_d_nx = m_d;
        s_v_nx = s_v;
        s_d_nx = s_d;
        h_v_nx = h_v;
        h_d_nx = h_d;
        rp_nx  = rp;

        if (flush_i) begin
            // Any downstream transfer this cycle is discarded along with the queue.
            m_v_nx = 1'b0;
            m_d_nx = '0;
            s_v_nx = 1'b0;
            s_d_nx = '0;
            h_v_nx = 1'b0;
            h_d_nx = '0;
            rp_nx  = 1'b0;
        end else if (rp) begin
            // Queue is frozen; the replayed beat leaving ends the replay.
            if (dn_fire) begin
                rp_nx = 1'b0;
            end
        end else begin
            if (dn_fire) begin
                // The departing main beat becomes the replay candidate.
                h_v_nx = 1'b1;
                h_d_nx = m_d;
                if (s_v) begin
                    m_d_nx = s_d;
                    s_v_nx = 1'b0;
                end else if (up_fire) begin
                    m_d_nx = up_data_i;
                end else begin
                    m_v_nx = 1'b0;
                end
            end else if (up_fire) begin
                if (!m_v) begin
                    m_d_nx = up_data_i;
                    m_v_nx = 1'b1;
                end else begin
                    s_d_nx = up_data_i;
                    s_v_nx = 1'b1;
                end
            end
            // A beat leaving this same cycle is already the new history.
            if (replay_i && (h_v || dn_fire)) begin
                rp_nx = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset to all zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v <= 1'b0;
            m_d <= '0;
            s_v <= 1'b0;
            s_d <= '0;
            h_v <= 1'b0;
            h_d <= '0;
            rp  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            m_v <= m_v_nx;
            m_d <= m_d_nx;
            s_v <= s_v_nx;
            s_d <= s_d_nx;
            h_v <= h_v_nx;
            h_d <= h_d_nx;
            rp  <= rp_nx;
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Count cycles with a valid beat refused downstream; saturate, flush clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (flush_i) begin
            stall_cnt <= '0;
        end else if (dn_valid_o && !dn_ready_i && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: a queue-level reference model is
// stepped on every clock edge and compared against the DUT on every falling
// edge; directed scenarios add literal expectations, then randomized traffic
// (including flush and replay) runs against the same model.
module tb_pipe_skid_reg;

    localparam int W = 40;

    logic         clk;
    logic         rst_n;
    logic         up_valid;
    logic         up_ready;
    logic [W-1:0] up_data;
    logic         dn_valid;
    logic         dn_ready;
    logic [W-1:0] dn_data;
    logic         flush;
    logic         replay;
    logic [1:0]   occupancy;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    pipe_skid_reg #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .up_valid_i  (up_valid),
        .up_ready_o  (up_ready),
        .up_data_i   (up_data),
        .dn_valid_o  (dn_valid),
        .dn_ready_i  (dn_ready),
        .dn_data_o   (dn_data),
        .flush_i     (flush),
        .replay_i    (replay),
        .occupancy_o (occupancy)
`ifdef PIPE_SKID_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of up to two queued beats (q0 is the head),
    // the last beat handed downstream, and a replay-pending flag.
    typedef struct packed {
        logic [1:0]   cnt;
        logic [W-1:0] q0;
        logic [W-1:0] q1;
        logic [W-1:0] h;
        logic         hv;
        logic         rp;
        logic [15:0]  sc;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t step(input mdl_t s, input logic uv, input logic [W-1:0] ud,
                                  input logic dr, input logic fl, input logic rq);
        mdl_t n;
        logic dv, ur, dfire, ufire;
        n     = s;
        dv    = s.rp || (s.cnt != 2'd0);
        ur    = (s.cnt < 2'd2) && !s.rp && !fl;
        dfire = dv && dr;
        ufire = uv && ur;
        if (dv && !dr && (s.sc != 16'hFFFF)) n.sc = s.sc + 16'd1;
        if (fl) begin
            n = '0;
        end else if (s.rp) begin
            if (dfire) n.rp = 1'b0;
        end else begin
            if (dfire) begin
                n.h   = s.q0;
                n.hv  = 1'b1;
                n.q0  = s.q1;
                n.cnt = s.cnt - 2'd1;
            end
            if (ufire) begin
                if (n.cnt == 2'd0) n.q0 = ud;
                else               n.q1 = ud;
                n.cnt = n.cnt + 2'd1;
            end
            if (rq && (s.hv || dfire)) n.rp = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl <= '0;
        else        mdl <= step(mdl, up_valid, up_data, dn_ready, flush, replay);
    end

    // Compare DUT outputs against the model on every falling edge.
    logic exp_dv;
    always @(negedge clk) begin
        exp_dv = mdl.rp || (mdl.cnt != 2'd0);
        check("dn_valid", 64'(dn_valid), 64'(exp_dv));
        check("up_ready", 64'(up_ready), 64'((mdl.cnt < 2'd2) && !mdl.rp && !flush));
        check("occupancy", 64'(occupancy), 64'(mdl.cnt));
        if (exp_dv) check("dn_data", 64'(dn_data), 64'(mdl.rp ? mdl.h : mdl.q0));
`ifdef PIPE_SKID_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(mdl.sc));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        up_valid = 1'b0;
        up_data  = '0;
        dn_ready = 1'b0;
        flush    = 1'b0;
        replay   = 1'b0;

        // Reset state.
        #2;
        check("rst_dn_valid", 64'(dn_valid), 64'd0);
        check("rst_up_ready", 64'(up_ready), 64'd1);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_dn_data", 64'(dn_data), 64'd0);
        #10 rst_n = 1'b1;
        tick();

        // Streaming: 1..4 back-to-back, one cycle of latency.
        dn_ready = 1'b1;
        up_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            up_data = W'(i);
            tick();
            check("stream_valid", 64'(dn_valid), 64'd1);
            check("stream_data", 64'(dn_data), 64'(i));
            check("stream_occ", 64'(occupancy), 64'd1);
            check("stream_ready", 64'(up_ready), 64'd1);
        end
        up_valid = 1'b0;
        tick();
        check("stream_drain", 64'(occupancy), 64'd0);

        // Back-pressure: A, B fill the stage; C is held off.
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data  = W'('hA);
        tick();
        up_data  = W'('hB);
        tick();
        check("bp_occ2", 64'(occupancy), 64'd2);
        check("bp_ready0", 64'(up_ready), 64'd0);
        up_data  = W'('hC);
        tick();
        check("bp_hold_occ", 64'(occupancy), 64'd2);
        check("bp_hold_A", 64'(dn_data), 64'hA);
        dn_ready = 1'b1;
        tick();
        check("bp_B", 64'(dn_data), 64'hB);
        tick();
        check("bp_C", 64'(dn_data), 64'hC);
        up_valid = 1'b0;
        tick();
        check("bp_empty", 64'(dn_valid), 64'd0);

        // Replay of a single beat with main emptying.
        up_valid = 1'b1;
        up_data  = W'('h55);
        tick();
        up_valid = 1'b0;
        replay   = 1'b1;
        tick();
        replay   = 1'b0;
        check("rp_valid", 64'(dn_valid), 64'd1);
        check("rp_data", 64'(dn_data), 64'h55);
        check("rp_ready0", 64'(up_ready), 64'd0);
        dn_ready = 1'b0;
        tick();
        check("rp_hold_ready0", 64'(up_ready), 64'd0);
        dn_ready = 1'b1;
        tick();
        check("rp_done_valid", 64'(dn_valid), 64'd0);
        check("rp_done_ready", 64'(up_ready), 64'd1);

        // Replay with a queued beat: order 66, 66, 77.
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data  = W'('h66);
        tick();
        up_data  = W'('h77);
        tick();
        up_valid = 1'b0;
        check("rpq_first", 64'(dn_data), 64'h66);
        dn_ready = 1'b1;
        replay   = 1'b1;
        tick();
        replay   = 1'b0;
        check("rpq_again", 64'(dn_data), 64'h66);
        check("rpq_occ", 64'(occupancy), 64'd1);
        tick();
        check("rpq_next", 64'(dn_data), 64'h77);
        tick();
        check("rpq_empty", 64'(dn_valid), 64'd0);

        // Flush with two beats queued and replay active.
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data  = W'('h88);
        tick();
        up_data  = W'('h99);
        tick();
        up_valid = 1'b0;
        replay   = 1'b1;
        tick();
        replay   = 1'b0;
        check("fl_pre_hist", 64'(dn_data), 64'h77);
        check("fl_pre_occ", 64'(occupancy), 64'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", 64'(dn_valid), 64'd0);
        check("fl_occ", 64'(occupancy), 64'd0);
        check("fl_data", 64'(dn_data), 64'd0);
        dn_ready = 1'b1;
        replay   = 1'b1;
        tick();
        replay   = 1'b0;
        check("fl_no_replay", 64'(dn_valid), 64'd0);

`ifdef PIPE_SKID_STALL_CNT_EN
        // Stall count: one valid beat refused for five cycles.
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data  = W'('h12);
        tick();
        up_valid = 1'b0;
        repeat (5) tick();
        check("stall_cnt5", 64'(stall_cnt), 64'd5);
        dn_ready = 1'b1;
        tick();
`endif

        // Asynchronous reset in the middle of a stalled stream.
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data  = W'('h31);
        tick();
        up_data  = W'('h32);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_dn_valid", 64'(dn_valid), 64'd0);
        check("mrst_up_ready", 64'(up_ready), 64'd1);
        check("mrst_occ", 64'(occupancy), 64'd0);
        check("mrst_dn_data", 64'(dn_data), 64'd0);
`ifdef PIPE_SKID_STALL_CNT_EN
        check("mrst_stall", 64'(stall_cnt), 64'd0);
`endif
        up_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Randomized traffic with occasional flush and replay.
        for (int c = 0; c < 3000; c++) begin
            up_valid = ($urandom_range(0, 3) != 0);
            up_data  = W'({$urandom(), $urandom()});
            dn_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            replay   = ($urandom_range(0, 9) == 0);
            tick();
        end
        up_valid = 1'b0;
        flush    = 1'b0;
        replay   = 1'b0;
        dn_ready = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
